cpu_control_fsm: RTL and testbench
==================================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3, giving the number of EXEC+MULWAIT cycles a MUL holds the ALU (legal 1..15).
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Opcode  input  4  instruction bits [23:20] from the instruction register.
REQ-005 SHALL have port Zero  input  1  ALU zero flag.
REQ-006 SHALL have port MemReady  input  1  memory completes the current read or write this cycle.
REQ-007 SHALL have outputs MemRead, MemWrite, IRWrite, PCWrite, RegWrite, MemToReg, ALUSrc, each 1 bit, with conventional datapath strobe meaning.
REQ-008 SHALL have port ALUOp  output  2  00 add, 01 subtract, 10 R-type decoded from Funct, 11 multiply.
REQ-009 SHALL have outputs Illegal (1, one-cycle pulse), Halted (1), State (3) and InstrCount (16, retired-instruction count).

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, MULWAIT=6, HALT=7, with State equal to the current encoding.
REQ-011 SHALL decode opcodes as: 0000 R-type, 0001 LS, 0010 SS, 0011 BEQ, 0100 BNE, 0101 MUL, 1111 HALT; all others illegal.
REQ-012 SHALL register Opcode at the DECODE edge and use only that registered value in EXEC, MEMRD, MEMWR, MULWAIT and WB.
REQ-013 FETCH: MemRead=1; while MemReady=0, remain; when MemReady=1, IRWrite=1 and PCWrite=1 for that cycle, then go to DECODE.
REQ-014 DECODE: legal non-HALT -> EXEC; HALT -> HALT; illegal -> Illegal=1 for this cycle, then FETCH, with InstrCount unchanged.
REQ-015 EXEC R-type: ALUOp=10, ALUSrc=0; next WB.
REQ-016 EXEC LS/SS: ALUOp=00, ALUSrc=1; next MEMRD for LS, MEMWR for SS.
REQ-017 EXEC BEQ/BNE: ALUOp=01, ALUSrc=0; PCWrite=Zero (BEQ) or ~Zero (BNE) in this cycle; next FETCH.
REQ-018 EXEC MUL: ALUOp=11; load the down-counter with MUL_CYCLES-1; next MULWAIT if MUL_CYCLES>1, otherwise WB.
REQ-019 MULWAIT: hold ALUOp=11 and decrement the counter each cycle; at counter==1 go to WB, so EXEC plus MULWAIT total exactly MUL_CYCLES cycles.
REQ-020 MEMRD: MemRead=1, ALUOp=00, ALUSrc=1 held; wait for MemReady; then WB.
REQ-021 MEMWR: MemWrite=1, ALUOp=00, ALUSrc=1 held; wait for MemReady; then FETCH.
REQ-022 WB: RegWrite=1 for exactly one cycle; MemToReg=1 only for LS; next FETCH.
REQ-023 HALT: Halted=1 and all strobes 0; remain until Reset.
REQ-024 SHALL increment InstrCount by 1 on every retirement: the exit from WB, the exit from MEMWR, and the exit from EXEC for BEQ/BNE; the count wraps 0xFFFF -> 0x0000 without a flag.
REQ-025 SHALL hold every strobe not listed for a state at 0, and ALUOp=00 in states other than EXEC, MEMRD, MEMWR and MULWAIT.
REQ-026 SHALL treat MemReady as don't-care outside FETCH, MEMRD and MEMWR.
REQ-027 SHALL keep all outputs Moore-style (functions of state and registered opcode only), except PCWrite in FETCH and EXEC-branch, and IRWrite in FETCH.

Reset
REQ-028 SHALL on Reset=0, asynchronously and regardless of state, force State=FETCH, InstrCount=0, the MUL counter to 0 and the registered opcode to 0000.
REQ-029 SHALL hold all outputs at 0 during reset, except MemRead=1 (the FETCH strobe) and State=0.
REQ-030 SHALL resume at the first rising edge after Reset returns to 1, starting in FETCH; an assertion mid-MULWAIT or mid-MEMWR SHALL abandon the instruction without RegWrite and without an InstrCount increment.

Verification
REQ-031 R-type, MemReady=1 always -> states 0,1,2,5,0; ALUOp=10 in EXEC; RegWrite is a single pulse; InstrCount 0->1.
REQ-032 LS with MemReady held 0 for 3 cycles in MEMRD -> MEMRD lasts 4 cycles; WB has MemToReg=1; SS -> MemWrite=1 until MemReady, then FETCH with RegWrite never 1.
REQ-033 BEQ with Zero=1 -> PCWrite=1 in EXEC; BEQ with Zero=0 and BNE with Zero=1 -> PCWrite=0 in EXEC; each increments InstrCount.
REQ-034 MUL with MUL_CYCLES=3 and MUL_CYCLES=1 -> ALUOp=11 for exactly 3 and 1 consecutive cycles respectively, then WB.
REQ-035 Opcode 1010 -> Illegal=1 for one cycle in DECODE, then FETCH, InstrCount unchanged; opcode 1111 -> Halted=1 held for 20+ cycles.
REQ-036 Preload InstrCount=0xFFFF (via 65535 retirements), retire one more -> 0x0000; Reset asserted mid-MULWAIT -> immediate FETCH and InstrCount=0.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multicycle CPU control unit: fetch/decode/execute sequencing,
// datapath strobes, multi-cycle MUL hold and retired-instruction count.
module cpu_control_fsm #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        Illegal,
  output logic        Halted,
  output logic [2:0]  State,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEMRD   = 3'd3,
    MEMWR   = 3'd4,
    WB      = 3'd5,
    MULWAIT = 3'd6,
    HALT    = 3'd7
  } state_t;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LS   = 4'd1;
  localparam logic [3:0] OP_SS   = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam bit         MUL_WAIT = (MUL_CYCLES > 1);

  state_t      state;
  logic [3:0]  opc;
  logic [3:0]  cnt;
  logic [15:0] icount;

  logic legal;
  logic is_br;
  logic retire;

  assign legal  = (Opcode <= OP_MUL) || (Opcode == OP_HALT);
  assign is_br  = (opc == OP_BEQ) || (opc == OP_BNE);
  assign retire = (state == WB)
               || (state == MEMWR && MemReady)
               || (state == EXEC && is_br);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= FETCH;
      opc    <= 4'd0;
      cnt    <= 4'd0;
      icount <= 16'd0;
    end else begin
      if (retire)
        icount <= icount + 16'd1;
      unique case (state)
        FETCH: begin
          if (MemReady)
            state <= DECODE;
        end
        DECODE: begin
          opc <= Opcode;
          unique case (1'b1)
            !legal:              state <= FETCH;
            (Opcode == OP_HALT): state <= HALT;
            default:             state <= EXEC;
          endcase
        end
        EXEC: begin
          case (opc)
            OP_R:  state <= WB;
            OP_LS: state <= MEMRD;
            OP_SS: state <= MEMWR;
            OP_MUL: begin
              cnt   <= MUL_LOAD;
              state <= MUL_WAIT ? MULWAIT : WB;
            end
            default: state <= FETCH;
          endcase
        end
        MULWAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1)
            state <= WB;
        end
        MEMRD: begin
          if (MemReady)
            state <= WB;
        end
        MEMWR: begin
          if (MemReady)
            state <= FETCH;
        end
        WB:   state <= FETCH;
        HALT: state <= HALT;
      endcase
    end
  end

  // Strobes decode from state/opc; FETCH handshake is gated by reset
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    Illegal  = 1'b0;
    Halted   = 1'b0;
    unique case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady && Reset;
        PCWrite = MemReady && Reset;
      end
      DECODE: Illegal = !legal;
      EXEC: begin
        case (opc)
          OP_R: ALUOp = 2'b10;
          OP_LS, OP_SS: ALUSrc = 1'b1;
          OP_BEQ: begin
            ALUOp   = 2'b01;
            PCWrite = Zero;
          end
          OP_BNE: begin
            ALUOp   = 2'b01;
            PCWrite = !Zero;
          end
          OP_MUL: ALUOp = 2'b11;
          default: ;
        endcase
      end
      MEMRD: begin
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        ALUSrc   = 1'b1;
      end
      WB: begin
        RegWrite = 1'b1;
        MemToReg = (opc == OP_LS);
      end
      MULWAIT: ALUOp = 2'b11;
      HALT:    Halted = 1'b1;
    endcase
  end

  assign State      = state;
  assign InstrCount = icount;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: stimulus queues expected
// per-cycle output vectors, a negedge monitor pops and compares.
module tb_cpu_control_fsm;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;

  logic [1:0] rd, wr, irw, pcw, rw, m2r, asrc, ill, hlt;
  logic [1:0]  aop [2];
  logic [2:0]  st  [2];
  logic [15:0] ic  [2];

  cpu_control_fsm #(.MUL_CYCLES(3)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .MemRead(rd[0]), .MemWrite(wr[0]),
    .IRWrite(irw[0]), .PCWrite(pcw[0]), .RegWrite(rw[0]),
    .MemToReg(m2r[0]), .ALUSrc(asrc[0]), .ALUOp(aop[0]),
    .Illegal(ill[0]), .Halted(hlt[0]), .State(st[0]),
    .InstrCount(ic[0])
  );

  cpu_control_fsm #(.MUL_CYCLES(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .MemRead(rd[1]), .MemWrite(wr[1]),
    .IRWrite(irw[1]), .PCWrite(pcw[1]), .RegWrite(rw[1]),
    .MemToReg(m2r[1]), .ALUSrc(asrc[1]), .ALUOp(aop[1]),
    .Illegal(ill[1]), .Halted(hlt[1]), .State(st[1]),
    .InstrCount(ic[1])
  );

  always #5 Clock = ~Clock;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2;
  localparam logic [2:0] S_MR = 3'd3, S_MW = 3'd4, S_W = 3'd5;
  localparam logic [2:0] S_MU = 3'd6, S_H = 3'd7;
  // strobe order: MemRead MemWrite IRWrite PCWrite RegWrite MemToReg ALUSrc
  localparam logic [6:0] SB_0   = 7'b0000000;
  localparam logic [6:0] SB_FW  = 7'b1000000;
  localparam logic [6:0] SB_FG  = 7'b1011000;
  localparam logic [6:0] SB_SRC = 7'b0000001;
  localparam logic [6:0] SB_PC  = 7'b0001000;
  localparam logic [6:0] SB_RD  = 7'b1000001;
  localparam logic [6:0] SB_WR  = 7'b0100001;
  localparam logic [6:0] SB_WB  = 7'b0000100;
  localparam logic [6:0] SB_WBL = 7'b0000110;
  localparam logic [3:0] X = 4'hA;

  typedef struct {
    bit          sel;
    logic [29:0] exp;
    string       tag;
  } rec_t;

  rec_t        q[$];
  int          ntests = 0;
  int          nfail = 0;
  logic [15:0] ecnt = 16'd0;

  function automatic logic [29:0] obs(input bit i);
    return {st[i], rd[i], wr[i], irw[i], pcw[i], rw[i], m2r[i],
            asrc[i], aop[i], ill[i], hlt[i], ic[i]};
  endfunction

  always @(negedge Clock) begin
    while (q.size() > 0) begin
      rec_t r;
      logic [29:0] got;
      r = q.pop_front();
      got = obs(r.sel);
      ntests++;
      if (got !== r.exp) begin
        nfail++;
        if (nfail <= 40)
          $display("FAIL %s: got st=%0d strb=%b aop=%b ill=%b hlt=%b cnt=%h, want st=%0d strb=%b aop=%b ill=%b hlt=%b cnt=%h",
                   r.tag, got[29:27], got[26:20], got[19:18], got[17],
                   got[16], got[15:0], r.exp[29:27], r.exp[26:20],
                   r.exp[19:18], r.exp[17], r.exp[16], r.exp[15:0]);
      end
    end
  end

  task automatic cyc(input string tag, input bit sel,
                     input logic [3:0] op, input bit z, input bit rdy,
                     input logic [2:0] s, input logic [6:0] sb,
                     input logic [1:0] a, input bit il = 1'b0,
                     input bit hl = 1'b0);
    Opcode = op;
    Zero = z;
    MemReady = rdy;
    q.push_back('{sel, {s, sb, a, il, hl, ecnt}, tag});
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0;
    MemReady = 1'b1;
    Opcode = X;
    Zero = 1'b1;
    ecnt = 16'd0;
    q.push_back('{1'b0, {S_F, SB_FW, 2'b00, 1'b0, 1'b0, 16'h0}, tag});
    q.push_back('{1'b1, {S_F, SB_FW, 2'b00, 1'b0, 1'b0, 16'h0}, tag});
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  task automatic fetch(input bit sel, input int waits);
    for (int i = 0; i < waits; i++)
      cyc("fetch_wait", sel, X, 1'b0, 1'b0, S_F, SB_FW, 2'b00);
    cyc("fetch", sel, X, 1'b0, 1'b1, S_F, SB_FG, 2'b00);
  endtask

  task automatic decode(input bit sel, input logic [3:0] op,
                        input bit il);
    cyc("decode", sel, op, 1'b0, 1'b0, S_D, SB_0, 2'b00, il);
  endtask

  task automatic run_r(input bit sel, input int fw);
    fetch(sel, fw);
    decode(sel, 4'd0, 1'b0);
    cyc("r_exec", sel, X, 1'b0, 1'b1, S_E, SB_0, 2'b10);
    cyc("r_wb", sel, X, 1'b0, 1'b1, S_W, SB_WB, 2'b00);
    ecnt++;
  endtask

  task automatic run_ls(input int waits);
    fetch(1'b0, 0);
    decode(1'b0, 4'd1, 1'b0);
    cyc("ls_exec", 1'b0, X, 1'b0, 1'b1, S_E, SB_SRC, 2'b00);
    for (int i = 0; i < waits; i++)
      cyc("ls_memrd_wait", 1'b0, X, 1'b0, 1'b0, S_MR, SB_RD, 2'b00);
    cyc("ls_memrd", 1'b0, X, 1'b0, 1'b1, S_MR, SB_RD, 2'b00);
    cyc("ls_wb", 1'b0, X, 1'b0, 1'b1, S_W, SB_WBL, 2'b00);
    ecnt++;
  endtask

  task automatic run_ss(input int waits);
    fetch(1'b0, 0);
    decode(1'b0, 4'd2, 1'b0);
    cyc("ss_exec", 1'b0, X, 1'b0, 1'b1, S_E, SB_SRC, 2'b00);
    for (int i = 0; i < waits; i++)
      cyc("ss_memwr_wait", 1'b0, X, 1'b0, 1'b0, S_MW, SB_WR, 2'b00);
    cyc("ss_memwr", 1'b0, X, 1'b0, 1'b1, S_MW, SB_WR, 2'b00);
    ecnt++;
  endtask

  task automatic run_br(input string tag, input logic [3:0] op,
                        input bit z);
    bit pc;
    pc = (op == 4'd3) ? z : !z;
    fetch(1'b0, 0);
    decode(1'b0, op, 1'b0);
    cyc(tag, 1'b0, X, z, 1'b1, S_E, pc ? SB_PC : SB_0, 2'b01);
    ecnt++;
  endtask

  task automatic run_mul(input bit sel, input int n);
    fetch(sel, 0);
    decode(sel, 4'd5, 1'b0);
    cyc("mul_exec", sel, X, 1'b0, 1'b1, S_E, SB_0, 2'b11);
    for (int i = 1; i < n; i++)
      cyc("mul_wait", sel, X, 1'b0, 1'b1, S_MU, SB_0, 2'b11);
    cyc("mul_wb", sel, X, 1'b0, 1'b1, S_W, SB_WB, 2'b00);
    ecnt++;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge Clock);
    #1;
    do_reset("reset");
    run_r(1'b0, 0);
    run_r(1'b0, 2);
    run_ls(3);
    run_ss(2);
    run_br("beq_taken", 4'd3, 1'b1);
    run_br("beq_not", 4'd3, 1'b0);
    run_br("bne_not", 4'd4, 1'b1);
    run_br("bne_taken", 4'd4, 1'b0);
    run_mul(1'b0, 3);
    fetch(1'b0, 0);
    decode(1'b0, 4'hA, 1'b1);
    run_r(1'b0, 0);

    fetch(1'b0, 0);
    decode(1'b0, 4'd5, 1'b0);
    cyc("mul_exec", 1'b0, X, 1'b0, 1'b1, S_E, SB_0, 2'b11);
    cyc("mul_wait", 1'b0, X, 1'b0, 1'b1, S_MU, SB_0, 2'b11);
    do_reset("reset_mulwait");
    run_r(1'b0, 0);

    fetch(1'b0, 0);
    decode(1'b0, 4'd2, 1'b0);
    cyc("ss_exec", 1'b0, X, 1'b0, 1'b1, S_E, SB_SRC, 2'b00);
    cyc("ss_memwr_wait", 1'b0, X, 1'b0, 1'b0, S_MW, SB_WR, 2'b00);
    do_reset("reset_memwr");
    run_r(1'b0, 0);

    do_reset("reset_m1");
    run_mul(1'b1, 1);
    fetch(1'b1, 0);

    do_reset("reset_halt");
    fetch(1'b0, 0);
    decode(1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 22; i++)
      cyc("halt", 1'b0, X, i[0], i[1], S_H, SB_0, 2'b00, 1'b0, 1'b1);

    do_reset("reset_wrap");
    for (int i = 0; i < 65535; i++)
      run_br("beq_bulk", 4'd3, 1'b1);
    run_r(1'b0, 0);
    fetch(1'b0, 0);

    @(negedge Clock);
    #1;
    ntests++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
